// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: access-size encodings,
// FSM states and the alignment rule.
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Size code 2'b11 falls into the word case.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEM_BYTE: is_misaligned = 1'b0;
            MEM_HALF: is_misaligned = addr_lo[0];
            default:  is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;

    logic        BusReq;
    logic        BusWr;
    logic [3:0]  BusBe;
    logic [31:0] BusAddr;
    logic [31:0] BusWdata;
    logic        BusAck;
    logic [31:0] BusRdata;

    modport master (
        output BusReq, BusWr, BusBe, BusAddr, BusWdata,
        input  BusAck, BusRdata
    );

    modport slave (
        input  BusReq, BusWr, BusBe, BusAddr, BusWdata,
        output BusAck, BusRdata
    );

endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store-side enables and replication, load-side
// extraction and extension, and the misalignment flag.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    output logic        misaligned,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_sign,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_be        = 4'b1111;
        st_wdata_rep = st_wdata;
        case (st_size)
            MEM_BYTE: begin
                st_be        = 4'b0001 << st_addr_lo;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            MEM_HALF: begin
                st_be        = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be        = 4'b1111;
                st_wdata_rep = st_wdata;
            end
        endcase
    end

    assign misaligned = is_misaligned(st_size, st_addr_lo);

    // Little-endian: the addressed byte lane moves down to bit 0.
    always_comb begin
        shifted = ld_rdata >> {ld_addr_lo, 3'b000};
        ld_data = shifted;
        case (ld_size)
            MEM_BYTE: ld_data = {{24{ld_sign & shifted[7]}}, shifted[7:0]};
            MEM_HALF: ld_data = {{16{ld_sign & shifted[15]}}, shifted[15:0]};
            default:  ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: launches one bus transaction per aligned MEM-stage
// access, stalls the pipeline until ack or timeout, and returns aligned load data.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MemEnM,
    input  logic                MemWriteM,
    input  logic [1:0]          MemSizeM,
    input  logic                MemSignM,
    input  logic [31:0]         ALUOutM,
    input  logic [31:0]         WriteDataM,
    output logic [31:0]         ReadDataM,
    output logic                MemStall,
    output logic                AdEL,
    output logic                AdES,
    output logic                BusErr,
    mem_access_unit_if.master   bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e      state;
    logic [7:0]  wait_cnt;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [3:0]  st_be;
    logic [31:0] st_wdata_rep;
    logic [31:0] ld_data;
    logic        misaligned;
    logic        trigger;

    mem_align u_align (
        .st_size      (MemSizeM),
        .st_addr_lo   (ALUOutM[1:0]),
        .st_wdata     (WriteDataM),
        .st_be        (st_be),
        .st_wdata_rep (st_wdata_rep),
        .misaligned   (misaligned),
        .ld_size      (size_q),
        .ld_addr_lo   (addr_lo_q),
        .ld_sign      (sign_q),
        .ld_rdata     (bus.BusRdata),
        .ld_data      (ld_data)
    );

    // Exceptions and new launches are only considered from IDLE, so a request
    // still held on the inputs during DONE is not relaunched.
    assign trigger  = (state == IDLE) && MemEnM && !misaligned;
    assign MemStall = trigger || (state == REQ);
    assign AdEL     = (state == IDLE) && MemEnM && misaligned && !MemWriteM;
    assign AdES     = (state == IDLE) && MemEnM && misaligned && MemWriteM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            addr_lo_q    <= 2'b00;
            size_q       <= 2'b00;
            sign_q       <= 1'b0;
            ReadDataM    <= 32'd0;
            BusErr       <= 1'b0;
            bus.BusReq   <= 1'b0;
            bus.BusWr    <= 1'b0;
            bus.BusBe    <= 4'd0;
            bus.BusAddr  <= 32'd0;
            bus.BusWdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    BusErr <= 1'b0;
                    if (trigger) begin
                        state        <= REQ;
                        wait_cnt     <= 8'd0;
                        addr_lo_q    <= ALUOutM[1:0];
                        size_q       <= MemSizeM;
                        sign_q       <= MemSignM;
                        bus.BusReq   <= 1'b1;
                        bus.BusWr    <= MemWriteM;
                        bus.BusBe    <= st_be;
                        bus.BusAddr  <= {ALUOutM[31:2], 2'b00};
                        bus.BusWdata <= st_wdata_rep;
                    end
                end
                REQ: begin
                    // An ack in the cycle the counter would expire takes priority.
                    if (bus.BusAck) begin
                        state      <= DONE;
                        bus.BusReq <= 1'b0;
                        if (!bus.BusWr) begin
                            ReadDataM <= ld_data;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= DONE;
                        bus.BusReq <= 1'b0;
                        BusErr     <= 1'b1;
                        ReadDataM  <= 32'd0;
                        wait_cnt   <= wait_cnt + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    BusErr <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    bus.BusReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit sitting directly downstream of the pipeline's MEM stage. It takes the stage's address/data/control, runs a request/acknowledge transaction on the data bus, and stalls the pipeline until the transfer completes. It also does byte-lane steering for sub-word stores, extraction and extension for sub-word loads, misalignment detection, and a bus-timeout watchdog.

## Interface
Parameters:
- MAX_WAIT, 255: maximum cycles spent in REQ without BusAck before a timeout is declared (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- MemEnM  in  1  MEM-stage instruction is a load or store.
- MemWriteM  in  1  1 = store, 0 = load (qualified by MemEnM).
- MemSizeM  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- MemSignM  in  1  loads: 1 sign-extend, 0 zero-extend.
- ALUOutM  in  32  effective byte address.
- WriteDataM  in  32  store data, right-aligned.
- ReadDataM  out  32  aligned, extended load result; reset 0.
- MemStall  out  1  holds the pipeline (combinational).
- AdEL  out  1  load misaligned, one-cycle pulse (combinational).
- AdES  out  1  store misaligned, one-cycle pulse (combinational).
- BusErr  out  1  timeout pulse, asserted in DONE; reset 0.
- BusReq  out  1  registered; reset 0.
- BusWr  out  1  registered; reset 0.
- BusBe  out  4  registered byte enables; reset 0.
- BusAddr  out  32  registered, word-aligned address; reset 0.
- BusWdata  out  32  registered, lane-replicated write data; reset 0.
- BusAck  in  1  transfer complete; BusRdata valid in the same cycle.
- BusRdata  in  32  read word.

## Operation
- States: IDLE, REQ, DONE.
- Misaligned access:
  - Half with addr[0]=1, or word with addr[1:0]≠0.
  - In IDLE this pulses AdEL or AdES; there is no bus access and no stall.
- IDLE:
  - Trigger: MemEnM and aligned.
  - On trigger: MemStall=1; register BusAddr={addr[31:2],2'b00}, BusWr, BusBe, BusWdata, addr[1:0], size and sign; go to REQ.
- REQ:
  - BusReq=1 and MemStall=1; bus outputs are held stable.
  - On BusAck: capture ReadDataM (loads only) and go to DONE.
  - On wait counter == MAX_WAIT: go to DONE, set BusErr=1, set ReadDataM=0.
- DONE:
  - BusReq=0 and MemStall=0; the pipeline advances at the end of this cycle.
  - The request still present on the inputs is not relaunched. Go to IDLE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Write data:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- Load data: shift BusRdata right by 8·addr[1:0], then sign- or zero-extend from bit 7 (byte) or bit 15 (half). Little-endian.
- Stores leave ReadDataM unchanged.
- Wait counter: 8 bits, cleared on entry to REQ, increments each REQ cycle without BusAck.

## Timing
- Cycle 0 (IDLE, trigger): MemStall=1.
- Cycle 1 (REQ): BusReq=1.
- BusAck in cycle k ≥ 1: DONE in k+1 with ReadDataM valid and MemStall=0.
- Minimum is 2 stall cycles. The first new request can be accepted at k+2.
- BusAck outside REQ is ignored.
- BusAck in the same cycle the counter reaches MAX_WAIT: the ack wins and BusErr=0.
- rst at any cycle, including mid-REQ:
  - Next cycle: IDLE, BusReq=0, all registered outputs 0, counter 0.
  - The aborted bus transfer is discarded.
- MemEnM deasserted while in REQ is ignored; the transaction completes.

## Structure
- Shared package mem_pkg:
  - size encodings MEM_BYTE/MEM_HALF/MEM_WORD;
  - state enum {IDLE, REQ, DONE}.
- Sub-module mem_align: combinational.
  - Store side: BusBe and write-data replication.
  - Load side: extract and extend.
  - Also produces the misalignment flag.
- Top level holds the FSM, the request registers and the wait counter.

## Test plan
- Word load, addr 0x100, BusRdata 0xDEADBEEF, ack on 3rd REQ cycle -> BusAddr 0x100, BusBe 1111, 4 stall cycles, ReadDataM 0xDEADBEEF in DONE.
- Signed byte load, addr 0x103, BusRdata 0x80FFFFFF -> BusBe 1000, ReadDataM 0xFFFFFF80. With MemSignM=0 -> 0x00000080.
- Half store 0x1234ABCD to addr 0x202 -> BusAddr 0x200, BusBe 1100, BusWdata 0xABCDABCD, BusWr=1.
- Word load at addr 0x101 -> AdEL pulse, no BusReq, MemStall=0. Half store at 0x103 -> AdES.
- No ack, MAX_WAIT=4 -> 4 REQ cycles, then DONE with BusErr=1 and ReadDataM=0. Variant: ack together with the 4th count -> BusErr=0.
- rst asserted on the 2nd REQ cycle -> next cycle BusReq=0, state IDLE. Then a fresh word load completes normally.
